// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks loads in ID_EX and EX_MEM, detects
// load-use dependencies for the instruction in ID and arbitrates between
// external stalls, taken-branch flushes and load-use bubbles.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_is_load,
  input  logic [4:0]             id_dest,
  input  logic                   ex_stall_c,
  input  logic                   mem_stall_c,
  input  logic                   ex_branch_taken,
  output logic                   if_stall_c,
  output logic                   id_stall_c,
  output logic                   id_bubble,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   exValid_q, exValid_d;
  logic [4:0]             exDest_q, exDest_d;
  logic                   memValid_q, memValid_d;
  logic [4:0]             memDest_q, memDest_d;
  logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic ext;
  logic rsHit;
  logic rtHit;
  logic hazard;

  // A source only conflicts if it is really read, is not r0, and matches an in-flight load
  always_comb begin
    ext    = ex_stall_c | mem_stall_c;
    rsHit  = id_uses_rs && (id_rs != 5'd0) &&
             ((exValid_q && (exDest_q == id_rs)) || (memValid_q && (memDest_q == id_rs)));
    rtHit  = id_uses_rt && (id_rt != 5'd0) &&
             ((exValid_q && (exDest_q == id_rt)) || (memValid_q && (memDest_q == id_rt)));
    hazard = id_valid && (rsHit || rtHit);
  end

  // Control outputs, forced quiet during reset; external stall beats branch beats load-use
  always_comb begin
    if_stall_c = 1'b0;
    id_stall_c = 1'b0;
    id_bubble  = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    if (reset_n) begin
      if (ext) begin
        if_stall_c = 1'b1;
        id_stall_c = 1'b1;
      end else if (ex_branch_taken) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else if (hazard) begin
        if_stall_c = 1'b1;
        id_stall_c = 1'b1;
        id_bubble  = 1'b1;
      end
    end
  end

  // Next-state for load slots, FSM and stall counter; everything freezes under an external stall
  always_comb begin
    state_d    = state_q;
    exValid_d  = exValid_q;
    exDest_d   = exDest_q;
    memValid_d = memValid_q;
    memDest_d  = memDest_q;
    stallCnt_d = stallCnt_q;

    if (!ext) begin
      memValid_d = exValid_q;
      memDest_d  = exDest_q;
      if (id_valid && id_is_load && !hazard && !ex_branch_taken) begin
        exValid_d = 1'b1;
        exDest_d  = id_dest;
      end else begin
        exValid_d = 1'b0;
        exDest_d  = 5'd0;
      end

      unique case (state_q)
        RUN:     state_d = ex_branch_taken ? FLUSH : (hazard ? LDSTALL : RUN);
        LDSTALL: state_d = ex_branch_taken ? FLUSH : (hazard ? LDSTALL : RUN);
        FLUSH:   state_d = ex_branch_taken ? FLUSH : RUN;
        default: state_d = RUN;
      endcase
    end

    if (id_stall_c && (stallCnt_q != {STALL_CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // All tracker state registers with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= RUN;
      exValid_q  <= 1'b0;
      exDest_q   <= 5'd0;
      memValid_q <= 1'b0;
      memDest_q  <= 5'd0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      exValid_q  <= exValid_d;
      exDest_q   <= exDest_d;
      memValid_q <= memValid_d;
      memDest_q  <= memDest_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-by-cycle vector table covering
// load-use stalls, r0, branch flushes, external stalls and reset, plus
// hand-written sequences for counter saturation and reset during FLUSH.
module tb_hazard_ctrl;

  logic        clock;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_load;
  logic [4:0]  id_dest;
  logic        ex_stall_c;
  logic        mem_stall_c;
  logic        ex_branch_taken;

  logic        if_stall_c, id_stall_c, id_bubble, if_flush, id_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  logic        ifStallB, idStallB, idBubbleB, ifFlushB, idFlushB;
  logic [1:0]  stateB;
  logic [3:0]  stallCntB;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         rstN;
    bit         valid;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         usesRs;
    bit         usesRt;
    bit         isLoad;
    logic [4:0] dest;
    bit         exS;
    bit         memS;
    bit         br;
    logic [4:0] expCtrl;
    logic [1:0] expState;
    int         expCnt;
  } vec_t;

  vec_t vecs[$];

  hazard_ctrl dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_load(id_is_load), .id_dest(id_dest),
    .ex_stall_c(ex_stall_c), .mem_stall_c(mem_stall_c), .ex_branch_taken(ex_branch_taken),
    .if_stall_c(if_stall_c), .id_stall_c(id_stall_c), .id_bubble(id_bubble),
    .if_flush(if_flush), .id_flush(id_flush), .state(state), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.STALL_CNT_W(4)) dutNarrow (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_load(id_is_load), .id_dest(id_dest),
    .ex_stall_c(ex_stall_c), .mem_stall_c(mem_stall_c), .ex_branch_taken(ex_branch_taken),
    .if_stall_c(ifStallB), .id_stall_c(idStallB), .id_bubble(idBubbleB),
    .if_flush(ifFlushB), .id_flush(idFlushB), .state(stateB), .stall_cnt(stallCntB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic addVec(input bit rstN, input bit valid, input logic [4:0] rs, input logic [4:0] rt,
                        input bit usesRs, input bit usesRt, input bit isLoad, input logic [4:0] dest,
                        input bit exS, input bit memS, input bit br,
                        input logic [4:0] expCtrl, input logic [1:0] expState, input int expCnt);
    vec_t v;
    v.rstN = rstN; v.valid = valid; v.rs = rs; v.rt = rt;
    v.usesRs = usesRs; v.usesRt = usesRt; v.isLoad = isLoad; v.dest = dest;
    v.exS = exS; v.memS = memS; v.br = br;
    v.expCtrl = expCtrl; v.expState = expState; v.expCnt = expCnt;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n         = v.rstN;
    id_valid        = v.valid;
    id_rs           = v.rs;
    id_rt           = v.rt;
    id_uses_rs      = v.usesRs;
    id_uses_rt      = v.usesRt;
    id_is_load      = v.isLoad;
    id_dest         = v.dest;
    ex_stall_c      = v.exS;
    mem_stall_c     = v.memS;
    ex_branch_taken = v.br;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [4:0] ctrlMain();
    return {if_stall_c, id_stall_c, id_bubble, if_flush, id_flush};
  endfunction

  function automatic logic [4:0] ctrlNarrow();
    return {ifStallB, idStallB, idBubbleB, ifFlushB, idFlushB};
  endfunction

  initial begin
    vec_t idle;
    idle = '{rstN: 1'b0, valid: 1'b0, rs: 5'd0, rt: 5'd0, usesRs: 1'b0, usesRt: 1'b0,
             isLoad: 1'b0, dest: 5'd0, exS: 1'b0, memS: 1'b0, br: 1'b0,
             expCtrl: 5'b0, expState: 2'd0, expCnt: 0};

    // ctrl = {if_stall_c, id_stall_c, id_bubble, if_flush, id_flush}
    //      rst v  rs  rt urs urt ld dest exS memS br  ctrl      st cnt
    // load r5 then dependent rs reader: two stall cycles, issues on the third
    addVec(1, 1, 0,  0, 0, 0, 1, 5,  0, 0, 0, 5'b00000, 0, 0);
    addVec(1, 1, 5,  0, 1, 0, 0, 9,  0, 0, 0, 5'b11100, 0, 0);
    addVec(1, 1, 5,  0, 1, 0, 0, 9,  0, 0, 0, 5'b11100, 1, 1);
    addVec(1, 1, 5,  0, 1, 0, 0, 9,  0, 0, 0, 5'b00000, 1, 2);
    // load r5, independent op, rt reader: one stall cycle
    addVec(1, 1, 0,  0, 0, 0, 1, 5,  0, 0, 0, 5'b00000, 0, 2);
    addVec(1, 1, 1,  2, 1, 1, 0, 3,  0, 0, 0, 5'b00000, 0, 2);
    addVec(1, 1, 0,  5, 0, 1, 0, 4,  0, 0, 0, 5'b11100, 0, 2);
    addVec(1, 1, 0,  5, 0, 1, 0, 4,  0, 0, 0, 5'b00000, 1, 3);
    // load r0 then r0 reader: never a hazard
    addVec(1, 1, 0,  0, 0, 0, 1, 0,  0, 0, 0, 5'b00000, 0, 3);
    addVec(1, 1, 0,  0, 1, 1, 0, 8,  0, 0, 0, 5'b00000, 0, 3);
    addVec(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 5'b00000, 0, 3);
    // hazard and taken branch together: flush wins, FLUSH twice via back-to-back branch
    addVec(1, 1, 0,  0, 0, 0, 1, 6,  0, 0, 0, 5'b00000, 0, 3);
    addVec(1, 1, 6,  0, 1, 0, 0, 2,  0, 0, 1, 5'b00011, 0, 3);
    addVec(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 5'b00011, 2, 3);
    addVec(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 5'b00000, 2, 3);
    addVec(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 5'b00000, 0, 3);
    // load r7 held by three cycles of mem stall, then reader still stalls twice
    addVec(1, 1, 0,  0, 0, 0, 1, 7,  0, 0, 0, 5'b00000, 0, 3);
    addVec(1, 1, 7,  0, 1, 0, 0, 1,  0, 1, 0, 5'b11000, 0, 3);
    addVec(1, 1, 7,  0, 1, 0, 0, 1,  0, 1, 0, 5'b11000, 0, 4);
    addVec(1, 1, 7,  0, 1, 0, 0, 1,  0, 1, 0, 5'b11000, 0, 5);
    addVec(1, 1, 7,  0, 1, 0, 0, 1,  0, 0, 0, 5'b11100, 0, 6);
    addVec(1, 1, 7,  0, 1, 0, 0, 1,  0, 0, 0, 5'b11100, 1, 7);
    addVec(1, 1, 7,  0, 1, 0, 0, 1,  0, 0, 0, 5'b00000, 1, 8);
    // ex stall beats a taken branch and holds the state
    addVec(1, 0, 0,  0, 0, 0, 0, 0,  1, 0, 1, 5'b11000, 0, 8);
    addVec(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 5'b00000, 0, 9);
    // reset in the middle of a load stall
    addVec(1, 1, 0,  0, 0, 0, 1, 4,  0, 0, 0, 5'b00000, 0, 9);
    addVec(1, 1, 4,  0, 1, 0, 0, 1,  0, 0, 0, 5'b11100, 0, 9);
    addVec(0, 1, 4,  0, 1, 0, 0, 1,  0, 0, 0, 5'b00000, 1, 10);
    addVec(1, 1, 4,  0, 1, 0, 0, 1,  0, 0, 0, 5'b00000, 0, 0);
    addVec(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 5'b00000, 0, 0);

    // Reset held with busy-looking inputs: every control output must stay low
    applyStimulus(idle);
    id_valid = 1'b1; id_rs = 5'd5; id_uses_rs = 1'b1;
    ex_stall_c = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checkOutput("ctrl_in_reset", -1, 32'(ctrlMain()), 32'd0);
    @(negedge clock);
    applyStimulus(idle);
    @(negedge clock);
    #1;
    checkOutput("state_after_reset", -1, 32'(state), 32'd0);
    checkOutput("cnt_after_reset", -1, 32'(stall_cnt), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("ctrl", i, 32'(ctrlMain()), 32'(vecs[i].expCtrl));
      checkOutput("ctrl_narrow", i, 32'(ctrlNarrow()), 32'(vecs[i].expCtrl));
      checkOutput("state", i, 32'(state), 32'(vecs[i].expState));
      checkOutput("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].expCnt));
      checkOutput("stall_cnt_narrow", i, 32'(stallCntB),
                  32'((vecs[i].expCnt > 15) ? 15 : vecs[i].expCnt));
    end

    // Twenty cycles of external stall: wide counter keeps counting, 4-bit one pins at 15
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      applyStimulus(idle);
      reset_n     = 1'b1;
      mem_stall_c = 1'b1;
      #1;
      checkOutput("sat_id_stall", i, 32'(id_stall_c), 32'd1);
      checkOutput("sat_cnt_narrow", i, 32'(stallCntB), 32'((i > 15) ? 15 : i));
    end
    @(negedge clock);
    applyStimulus(idle);
    reset_n         = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    checkOutput("sat_cnt_wide", 0, 32'(stall_cnt), 32'd20);
    checkOutput("sat_cnt_narrow_final", 0, 32'(stallCntB), 32'd15);
    checkOutput("branch_ctrl", 0, 32'(ctrlMain()), 32'b00011);

    // Reset during FLUSH aborts it
    @(negedge clock);
    applyStimulus(idle);
    #1;
    checkOutput("flush_state", 0, 32'(state), 32'd2);
    checkOutput("ctrl_in_reset2", 0, 32'(ctrlMain()), 32'd0);
    @(negedge clock);
    applyStimulus(idle);
    reset_n = 1'b1;
    #1;
    checkOutput("state_after_flush_reset", 0, 32'(state), 32'd0);
    checkOutput("cnt_after_flush_reset", 0, 32'(stall_cnt), 32'd0);
    checkOutput("cnt_narrow_after_flush_reset", 0, 32'(stallCntB), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
